rr_grant_mux: RTL

- Downstream consumer of the round-robin arbiter's one-hot grant. Requests arbitration on behalf of N packetised sources.
- Locks the granted source for a whole packet (through s_last). Forwards its beats through a one-deep registered output stage to a single shared sink.
- Drives the arbiter's en/req_vld and samples its registered o_grant.

---
 rtl/rr_grant_mux_pkg.sv | 45 ++++
 rtl/rr_grant_mux_out.sv | 36 +++
 rtl/rr_grant_mux.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rr_grant_mux_pkg.sv
// rr_grant_mux shared types and helpers.
// Channel count, beat layout, FSM encoding.
package rr_grant_mux_pkg;

  localparam int N               = 3;
  localparam int DW              = 32;
  localparam int GNT_TIMEOUT_DEF = 15;

  // ceil(log2(v)), never below 1
  function automatic int clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int SW = clog2(N);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    XFER     = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [SW-1:0] src;
  } beat_t;

  function automatic logic is_onehot(
    input logic [N-1:0] v
  );
    return $onehot(v);
  endfunction

  function automatic logic [SW-1:0] oh2idx(
    input logic [N-1:0] v
  );
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx |= SW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_mux_out.sv
// rr_out_reg: one-deep registered valid/ready stage.
// Carries {data, last, src} to the shared sink.
module rr_out_reg
  import rr_grant_mux_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  in_valid_i,
  input  beat_t in_beat_i,
  output logic  in_ready_o,
  output logic  out_valid_o,
  output beat_t out_beat_o,
  input  logic  out_ready_i
);

  logic  valid_q;
  beat_t beat_q;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_beat_o  = beat_q;

  // load on accept, drain on sink ready, else hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      beat_q  <= in_beat_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_grant_mux.sv
// rr_grant_mux: requests arbitration, locks the
// granted source for a packet, forwards its beats.
module rr_grant_mux
  import rr_grant_mux_pkg::*;
#(
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    s_valid,
  input  logic [N*DW-1:0] s_data,
  input  logic [N-1:0]    s_last,
  output logic [N-1:0]    s_ready,
  output logic            arb_en,
  output logic [N-1:0]    arb_req,
  input  logic [N-1:0]    arb_grant,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic [SW-1:0]   m_src,
  input  logic            m_ready,
  output logic            err_multi_gnt,
  output logic            err_timeout,
  output logic [15:0]     pkt_cnt
);

  localparam int CW = clog2(GNT_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  lock_q, lock_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          emg_q, emg_d;
  logic          eto_q, eto_d;
  logic [15:0]   pkt_q, pkt_d;

  logic [SW-1:0] sel;
  logic          sel_vld;
  logic          sel_last;
  logic          acc;
  logic          out_rdy;
  logic          gnt_ok;
  logic          gnt_multi;
  beat_t         in_beat;
  beat_t         out_beat;

  assign sel      = oh2idx(lock_q);
  assign sel_vld  = s_valid[sel];
  assign sel_last = s_last[sel];

  assign in_beat.data = s_data[sel*DW +: DW];
  assign in_beat.last = sel_last;
  assign in_beat.src  = sel;

  assign gnt_ok = is_onehot(arb_grant)
                & |(arb_grant & s_valid);
  assign gnt_multi = (arb_grant != '0)
                   & ~is_onehot(arb_grant);

  // next state, arbiter handshake, source ready
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    emg_d   = emg_q;
    eto_d   = 1'b0;
    pkt_d   = pkt_q;
    arb_en  = 1'b0;
    arb_req = '0;
    s_ready = '0;
    acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|s_valid) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        arb_en  = 1'b1;
        arb_req = s_valid;
        if (gnt_ok) begin
          lock_d  = arb_grant;
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          if (gnt_multi) emg_d = 1'b1;
          if (cnt_q == CW'(GNT_TIMEOUT)) begin
            eto_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      XFER: begin
        s_ready[sel] = out_rdy;
        acc = sel_vld & out_rdy;
        if (acc && sel_last) begin
          lock_d  = '0;
          pkt_d   = pkt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      lock_q  <= '0;
      cnt_q   <= '0;
      emg_q   <= 1'b0;
      eto_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      emg_q   <= emg_d;
      eto_q   <= eto_d;
      pkt_q   <= pkt_d;
    end
  end

  rr_out_reg u_out (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (acc),
    .in_beat_i   (in_beat),
    .in_ready_o  (out_rdy),
    .out_valid_o (m_valid),
    .out_beat_o  (out_beat),
    .out_ready_i (m_ready)
  );

  assign m_data        = out_beat.data;
  assign m_last        = out_beat.last;
  assign m_src         = out_beat.src;
  assign err_multi_gnt = emg_q;
  assign err_timeout   = eto_q;
  assign pkt_cnt       = pkt_q;

endmodule
